// File: rtl/noc_pkg.sv
// Shared router definitions: default port/word geometry, the output arbiter
// state encoding and the helper that locates a port's slice in a flat bus.
package noc_pkg;

  localparam int NOC_NUM_PORTS  = 4;
  localparam int NOC_WORD_WIDTH = 128;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_XFER = 2'd3
  } arb_state_e;

  // Low bit of port idx inside a flat {port N-1, ..., port 0} data bus.
  function automatic int unsigned port_slice_lo(input int unsigned idx,
                                                input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set bit of req scanning upward
// from last_grant+1 with wrap; found is low when req is all zero.
module rr_picker #(
  parameter int N     = 4,
  parameter int LOG_N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [LOG_N-1:0] last_grant,
  output logic [LOG_N-1:0] pick,
  output logic             found
);

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last_grant) + k) % N]) begin
        found = 1'b1;
        pick  = LOG_N'((int'(last_grant) + k) % N);
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Round-robin output arbiter: grants one buffered port at a time and forwards
// its drained word stream. Define OUTPUT_ARBITER_PERF_EN for word/grant counters.
module output_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS     = NOC_NUM_PORTS,
  parameter int LOG_NUM_PORTS = 2,
  parameter int WORD_WIDTH    = NOC_WORD_WIDTH,
  parameter int WAIT_TIMEOUT  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_empty,
  input  logic [NUM_PORTS-1:0]            port_is_writing,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] port_data,
  output logic [NUM_PORTS-1:0]            port_read_enable,
  output logic [WORD_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic [LOG_NUM_PORTS-1:0]        grant_id,
  output logic                            busy,
  output logic                            timeout_err,
`ifdef OUTPUT_ARBITER_PERF_EN
  output logic [31:0]                     word_count,
  output logic [15:0]                     grant_count,
`endif
  output arb_state_e                      state_dbg
);

  // Handshake: port_read_enable is a one-cycle, one-hot drain request issued
  // only from REQ; the granted port answers with port_is_writing high for each
  // valid word, and its first low cycle marks the end of the burst.

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

  arb_state_e               state;
  logic [LOG_NUM_PORTS-1:0] last_grant;
  logic [LOG_NUM_PORTS-1:0] pick;
  logic                     found;
  logic [WCW-1:0]           wait_cnt;
  logic                     gnt_writing;
  logic [WORD_WIDTH-1:0]    gnt_data;

  rr_picker #(
    .N    (NUM_PORTS),
    .LOG_N(LOG_NUM_PORTS)
  ) u_picker (
    .req       (~port_empty),
    .last_grant(last_grant),
    .pick      (pick),
    .found     (found)
  );

  assign gnt_writing = port_is_writing[grant_id];
  assign gnt_data    = port_data[port_slice_lo(32'(grant_id), WORD_WIDTH) +: WORD_WIDTH];
  assign busy        = (state != ARB_IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ARB_IDLE;
      port_read_enable <= '0;
      out_data         <= '0;
      out_valid        <= 1'b0;
      grant_id         <= '0;
      timeout_err      <= 1'b0;
      last_grant       <= LOG_NUM_PORTS'(NUM_PORTS - 1);
      wait_cnt         <= '0;
    end else begin
      port_read_enable <= '0;
      timeout_err      <= 1'b0;
      case (state)
        ARB_IDLE: begin
          out_valid <= 1'b0;
          if (found) begin
            grant_id         <= pick;
            port_read_enable <= NUM_PORTS'(1) << pick;
            state            <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          wait_cnt <= '0;
          state    <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (gnt_writing) begin
            out_data  <= gnt_data;
            out_valid <= 1'b1;
            state     <= ARB_XFER;
          end else if (wait_cnt == WCW'(WAIT_TIMEOUT - 1)) begin
            // Port never answered; rotate past it so others are not starved.
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            state       <= ARB_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ARB_XFER: begin
          if (gnt_writing) begin
            out_data  <= gnt_data;
            out_valid <= 1'b1;
          end else begin
            out_valid  <= 1'b0;
            last_grant <= grant_id;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count  <= '0;
      grant_count <= '0;
    end else begin
      if (out_valid)         word_count  <= word_count + 32'd1;
      if (state == ARB_REQ)  grant_count <= grant_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter with a behavioural FIFO model per port
// and a monitor that logs output words, grants and timeout pulses.
module tb_output_arbiter;
  import noc_pkg::*;

  localparam int NP = 4;
  localparam int LP = 2;
  localparam int WW = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    port_empty      = '1;
  logic [NP-1:0]    port_is_writing = '0;
  logic [NP*WW-1:0] port_data       = '0;
  logic [NP-1:0]    port_read_enable;
  logic [WW-1:0]    out_data;
  logic             out_valid;
  logic [LP-1:0]    grant_id;
  logic             busy;
  logic             timeout_err;
  arb_state_e       state_dbg;
`ifdef OUTPUT_ARBITER_PERF_EN
  logic [31:0]      word_count;
  logic [15:0]      grant_count;
`endif

  output_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .port_empty      (port_empty),
    .port_is_writing (port_is_writing),
    .port_data       (port_data),
    .port_read_enable(port_read_enable),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .grant_id        (grant_id),
    .busy            (busy),
    .timeout_err     (timeout_err),
`ifdef OUTPUT_ARBITER_PERF_EN
    .word_count      (word_count),
    .grant_count     (grant_count),
`endif
    .state_dbg       (state_dbg)
  );

  // ---------------- port buffer model ----------------
  // A port sees read_enable at one negedge and presents its first word two
  // negedges later, then one word per cycle until its FIFO runs dry.
  logic [WW-1:0] fifo [NP][$];
  int            arm      [NP];
  bit            draining [NP];
  bit            mute     [NP];

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (!rst) begin
        fifo[p].delete();
        arm[p]             = 0;
        draining[p]        = 1'b0;
        port_is_writing[p] = 1'b0;
        port_data[p*WW +: WW] = '0;
      end else begin
        if (port_read_enable[p] && !mute[p]) arm[p] = 2;
        else if (arm[p] > 0) begin
          arm[p] = arm[p] - 1;
          if (arm[p] == 0) draining[p] = 1'b1;
        end
        if (draining[p] && fifo[p].size() > 0) begin
          port_is_writing[p]    = 1'b1;
          port_data[p*WW +: WW] = fifo[p].pop_front();
        end else begin
          port_is_writing[p] = 1'b0;
          draining[p]        = 1'b0;
        end
      end
      port_empty[p] = (fifo[p].size() == 0);
    end
  end

  // ---------------- monitor ----------------
  logic [WW-1:0] obs_q[$];
  logic [WW-1:0] exp_q[$];
  logic [LP-1:0] grant_log[$];
  logic [NP-1:0] re_last;
  int cyc = 0, re_cycles = 0, re_bad = 0, bursts = 0, min_gap = 1000;
  int last_valid_cyc = 0, tmo_cnt = 0, tmo_delta = 0, last_re_cyc = 0;
  bit prev_valid = 1'b0, have_burst = 1'b0;
  arb_state_e tmo_state = ARB_XFER;

  always @(negedge clk) begin
    cyc++;
    if (|port_read_enable) begin
      re_cycles++;
      last_re_cyc = cyc;
      re_last     = port_read_enable;
      if (!$onehot(port_read_enable) || state_dbg != ARB_REQ) re_bad++;
      for (int p = 0; p < NP; p++)
        if (port_read_enable[p]) grant_log.push_back(LP'(p));
    end
    if (out_valid) begin
      obs_q.push_back(out_data);
      if (!prev_valid) begin
        if (have_burst && (cyc - last_valid_cyc - 1) < min_gap)
          min_gap = cyc - last_valid_cyc - 1;
        have_burst = 1'b1;
        bursts++;
      end
      last_valid_cyc = cyc;
    end
    if (timeout_err) begin
      tmo_cnt++;
      tmo_delta = cyc - last_re_cyc;
      tmo_state = state_dbg;
    end
    prev_valid = out_valid;
  end

  // ---------------- scoreboard helpers ----------------
  int tests  = 0;
  int failed = 0;

  function automatic logic [WW-1:0] word(input int p, input int i);
    return {8'(p), 8'(i), {14{8'hA5}}};
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_stream(input string tag);
    int n;
    chk({tag, "_len"}, WW'(obs_q.size()), WW'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, obs_q[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); grant_log.delete();
    re_cycles = 0; re_bad = 0; bursts = 0; min_gap = 1000;
    have_burst = 1'b0; tmo_cnt = 0; tmo_delta = 0; re_last = '0;
  endtask

  task automatic load(input int p, input int first, input int n);
    for (int i = 0; i < n; i++) fifo[p].push_back(word(p, first + i));
  endtask

  task automatic expect_words(input int p, input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(word(p, first + i));
  endtask

  task automatic wait_quiet(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(posedge clk); #1;
      ok = (busy === 1'b0);
      for (int p = 0; p < NP; p++)
        if (fifo[p].size() != 0 || draining[p] || arm[p] != 0) ok = 1'b0;
    end
    chk({tag, "_done"}, WW'(ok), WW'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_re"},    WW'(port_read_enable), '0);
    chk({tag, "_data"},  out_data, '0);
    chk({tag, "_valid"}, WW'(out_valid), '0);
    chk({tag, "_gid"},   WW'(grant_id), '0);
    chk({tag, "_busy"},  WW'(busy), '0);
    chk({tag, "_tmo"},   WW'(timeout_err), '0);
    chk({tag, "_state"}, WW'(state_dbg), WW'(ARB_IDLE));
`ifdef OUTPUT_ARBITER_PERF_EN
    chk({tag, "_wcnt"},  WW'(word_count), '0);
    chk({tag, "_gcnt"},  WW'(grant_count), '0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit hit;
    for (int p = 0; p < NP; p++) mute[p] = 1'b0;
    re_last = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Port 2 alone with three words
    clear_logs();
    @(posedge clk); #1;
    load(2, 0, 3); expect_words(2, 0, 3);
    wait_quiet("t1");
    chk_stream("t1");
    chk("t1_re_cycles", WW'(re_cycles), WW'(1));
    chk("t1_re_vec",    WW'(re_last), WW'(4'b0100));
    chk("t1_grant_id",  WW'(grant_id), WW'(2));
    chk("t1_busy",      WW'(busy), WW'(0));
    chk("t1_bursts",    WW'(bursts), WW'(1));
    chk("t1_re_bad",    WW'(re_bad), WW'(0));

    // All four ports after reset: order 0,1,2,3 then port 0 again
    do_reset();
    clear_logs();
    for (int p = 0; p < NP; p++) begin
      load(p, 0, 2); expect_words(p, 0, 2);
    end
    expect_words(0, 2, 2);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      hit = (grant_log.size() >= 2);
    end
    chk("t2_second_grant_seen", WW'(hit), WW'(1));
    load(0, 2, 2);
    wait_quiet("t2");
    chk_stream("t2");
    chk("t2_grant_cnt", WW'(grant_log.size()), WW'(5));
    if (grant_log.size() == 5) begin
      chk("t2_g0", WW'(grant_log[0]), WW'(0));
      chk("t2_g1", WW'(grant_log[1]), WW'(1));
      chk("t2_g2", WW'(grant_log[2]), WW'(2));
      chk("t2_g3", WW'(grant_log[3]), WW'(3));
      chk("t2_g4", WW'(grant_log[4]), WW'(0));
    end
    chk("t2_re_cycles", WW'(re_cycles), WW'(5));
    chk("t2_bursts",    WW'(bursts), WW'(5));
    chk("t2_gap_ge3",   WW'(min_gap >= 3), WW'(1));
    chk("t2_re_bad",    WW'(re_bad), WW'(0));

    // Port 1 burst extended by two writes during XFER
    clear_logs();
    @(posedge clk); #1;
    load(1, 0, 3); expect_words(1, 0, 5);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(posedge clk); #1;
      hit = (obs_q.size() >= 1);
    end
    chk("t3_first_word_seen", WW'(hit), WW'(1));
    load(1, 3, 2);
    wait_quiet("t3");
    chk_stream("t3");
    chk("t3_bursts",    WW'(bursts), WW'(1));
    chk("t3_grant_id",  WW'(grant_id), WW'(1));

    // Port 3 never answers: timeout, then port 0
    clear_logs();
    mute[3] = 1'b1;
    @(posedge clk); #1;
    load(3, 0, 1); load(0, 0, 2); expect_words(0, 0, 2);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(posedge clk); #1;
      hit = (tmo_cnt >= 1);
    end
    chk("t4_timeout_seen", WW'(hit), WW'(1));
    fifo[3].delete();
    mute[3] = 1'b0;
    wait_quiet("t4");
    chk_stream("t4");
    chk("t4_tmo_pulses",  WW'(tmo_cnt), WW'(1));
    chk("t4_tmo_delay",   WW'(tmo_delta), WW'(5));
    chk("t4_tmo_state",   WW'(tmo_state), WW'(ARB_IDLE));
    chk("t4_grant_cnt",   WW'(grant_log.size()), WW'(2));
    if (grant_log.size() == 2) begin
      chk("t4_g0", WW'(grant_log[0]), WW'(3));
      chk("t4_g1", WW'(grant_log[1]), WW'(0));
    end

    // Reset in the middle of a five-word burst from port 2
    clear_logs();
    @(posedge clk); #1;
    load(2, 0, 5);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk); #1;
      hit = (obs_q.size() >= 2);
    end
    chk("t5_word2_seen", WW'(hit), WW'(1));
    if (obs_q.size() >= 2) chk("t5_word2", obs_q[1], word(2, 1));
    rst = 1'b0;
    #1;
    chk_reset_outputs("t5_midreset");
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    clear_logs();
    @(posedge clk); #1;
    load(3, 0, 5); load(1, 0, 3);
    expect_words(1, 0, 3); expect_words(3, 0, 5);
    wait_quiet("t5");
    chk_stream("t5");
    chk("t5_grant_cnt", WW'(grant_log.size()), WW'(2));
    if (grant_log.size() == 2) begin
      chk("t5_g0", WW'(grant_log[0]), WW'(1));
      chk("t5_g1", WW'(grant_log[1]), WW'(3));
    end
`ifdef OUTPUT_ARBITER_PERF_EN
    chk("perf_word_count",  WW'(word_count), WW'(8));
    chk("perf_grant_count", WW'(grant_count), WW'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Downstream stage of the router input-port buffers: arbitrates among NUM_PORTS buffered ports, grants one at a time, and forwards the granted port's drained word stream onto a single output link. Selection is round-robin. A grant is held until the granted port finishes draining its buffer, which it signals by deasserting is_writing. The block sits between the per-port FIFOs and the output link register of each router output.

## Interface
- NUM_PORTS, 4, number of upstream port buffers arbitrated
- LOG_NUM_PORTS, 2, width of port index
- WORD_WIDTH, 128, flit/word width
- WAIT_TIMEOUT, 4, max cycles from read_enable pulse to first is_writing before abandoning the grant
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset (low = reset)
- port_empty  input  NUM_PORTS  per-port buffer-empty flag
- port_is_writing  input  NUM_PORTS  per-port "data_out valid this cycle"
- port_data  input  NUM_PORTS*WORD_WIDTH  per-port data_out, port i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- port_read_enable  output  NUM_PORTS  one-hot, single-cycle request to the selected port
- out_data  output  WORD_WIDTH  registered output word
- out_valid  output  1  out_data valid
- grant_id  output  LOG_NUM_PORTS  index of currently or last granted port
- busy  output  1  high in any state except IDLE
- timeout_err  output  1  single-cycle pulse when WAIT times out

## Operation
- States: IDLE, REQ, WAIT, XFER.
- IDLE: if any port_empty bit is low, select the first non-empty port scanning from (last_grant+1) mod NUM_PORTS upward with wrap. Latch the selection into grant_id and go to REQ. If all ports are empty, stay in IDLE.
- REQ: drive port_read_enable[grant_id]=1 for exactly this cycle, clear the wait counter, go to WAIT.
- WAIT: if port_is_writing[grant_id]=1, capture the word and go to XFER. Otherwise increment the wait counter. When the counter reaches WAIT_TIMEOUT, pulse timeout_err, set last_grant=grant_id, and go to IDLE.
- XFER: each cycle port_is_writing[grant_id]=1, register port_data slice into out_data with out_valid=1. The first cycle it is 0, set out_valid=0, last_grant=grant_id, go to IDLE.
- is_writing/empty of non-granted ports are ignored outside IDLE.
- Writes into the granted port during XFER extend the burst. This is legal, and the burst length is unbounded.
- port_read_enable is never asserted outside REQ, and never more than one bit at a time.

## Timing
- Reset (rst low, asynchronous): state=IDLE, port_read_enable=0, out_data=0, out_valid=0, grant_id=0, busy=0, timeout_err=0, last_grant=NUM_PORTS-1 so that port 0 wins first.
- Grant latency: non-empty seen in IDLE at edge N, then REQ at N+1, with read_enable high during cycle N+1.
- The port's first is_writing arrives two edges after read_enable is sampled.
- out_valid lags port_is_writing by exactly one cycle. out_data matches the port word from the previous cycle.
- Back-to-back grants: IDLE is always visited for at least one cycle between bursts, giving a minimum gap of 3 cycles between out_valid bursts.
- Reset mid-XFER: output is dropped immediately and no partial word is held.
- grant_id holds its value in IDLE until the next selection.

## Configuration
- OUTPUT_ARBITER_PERF_EN defined:
  - Adds output word_count (32 bit), which increments on every out_valid cycle and wraps at 2^32.
  - Adds output grant_count (16 bit), which increments on every REQ and wraps.
  - Both counters reset to 0.
- OUTPUT_ARBITER_PERF_EN undefined: the counters and their ports do not exist.

## Structure
- The shared noc_pkg holds:
  - WORD_WIDTH and NUM_PORTS defaults
  - the arbiter state encoding (IDLE=0, REQ=1, WAIT=2, XFER=3)
  - the port-slice index helper
- Sub-module rr_picker: combinational round-robin select, taking request vector and last_grant and producing the index plus a found flag. It is reused by other router arbiters.

## Test plan
- Reset, then port 2 non-empty with 3 words A,B,C:
  - read_enable=4'b0100 for one cycle
  - out_valid high for exactly 3 cycles with A,B,C
  - grant_id=2
  - back to IDLE, busy=0
- All four ports non-empty after reset: grant order 0,1,2,3,0.
  - Each grant has one read_enable pulse.
  - No overlap of out_valid bursts, with gap ≥3 cycles.
- Port 1 granted, then 2 extra words written during XFER: burst length equals 3 original + 2 extra words, in order.
- Port 3 non-empty but is_writing never rises:
  - after 4 WAIT cycles, timeout_err pulses once and the block returns to IDLE
  - the next grant goes to port 0 if it is non-empty
- rst low mid-XFER on word 2 of 5: out_valid drops immediately and all outputs are at reset values. After release, the first grant goes to the lowest non-empty port.
- With OUTPUT_ARBITER_PERF_EN: two bursts of 3 and 5 words give word_count=8 and grant_count=2.
